// File: rtl/acc_ctrl_seq_pkg.sv
// ISA, ALU and state encodings shared by the accumulator
// control sequencer and its wait counter.
package acc_ctrl_seq_pkg;

  localparam logic [2:0] OP_LDA = 3'b000;
  localparam logic [2:0] OP_STA = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_JMP = 3'b101;
  localparam logic [2:0] OP_JZ  = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;
  localparam logic [1:0] ALU_AND  = 2'b11;

  localparam logic [2:0] S_FETCH0 = 3'd0;
  localparam logic [2:0] S_FETCH1 = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  function automatic logic is_rd(input logic [2:0] op);
    return (op == OP_LDA) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_AND);
  endfunction

  function automatic logic is_mem(input logic [2:0] op);
    return is_rd(op) || (op == OP_STA);
  endfunction

  function automatic logic [1:0] alu_sel(input logic [2:0] op);
    logic [1:0] sel;
    sel = ALU_PASS;
    unique case (1'b1)
      (op == OP_ADD): sel = ALU_ADD;
      (op == OP_SUB): sel = ALU_SUB;
      (op == OP_AND): sel = ALU_AND;
      default:        sel = ALU_PASS;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/acc_ctrl_seq_mem_wait_cnt.sv
// Memory wait counter: counts read-latency cycles while
// advancing, flags the last one, clears on request.
module mem_wait_cnt #(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic clr,
  input  logic adv,
  output logic done
);

  localparam int W = $clog2(MEM_LAT) + 1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign done = (cnt_q == W'(MEM_LAT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (adv && !done)
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

endmodule

// File: rtl/acc_ctrl_seq.sv
// Fetch/decode/execute control sequencer for the
// accumulator processor datapath.
module acc_ctrl_seq
  import acc_ctrl_seq_pkg::*;
#(
  parameter int OP_W    = 3,
  parameter int CNT_W   = 16,
  parameter int MEM_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [OP_W-1:0]  ir_op,
  input  logic             acc_zero,
  output logic             reg_clr_n,
  output logic             pc_set,
  output logic             pc_inc,
  output logic             mar_set,
  output logic             mar_src,
  output logic             ir_set,
  output logic             acc_set,
  output logic [1:0]       alu_op,
  output logic             mem_we,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt
);

  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [2:0]       op;
  logic             done;
  logic             retire;
  logic             wait_clr;
  logic             wait_adv;

  assign op        = ir_op;
  assign wait_clr  = rst || (state_d != state_q);
  assign wait_adv  = (state_q == S_FETCH1) ||
                     (state_q == S_EXEC);
  assign reg_clr_n = ~rst;
  assign instr_cnt = cnt_q;

  mem_wait_cnt #(
    .MEM_LAT(MEM_LAT)
  ) u_wait (
    .clk (clk),
    .clr (wait_clr),
    .adv (wait_adv),
    .done(done)
  );

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    unique case (state_q)
      S_FETCH0: if (run) state_d = S_FETCH1;
      S_FETCH1: if (done) state_d = S_DECODE;
      S_DECODE: begin
        if (is_mem(op)) begin
          state_d = S_EXEC;
        end else begin
          retire  = 1'b1;
          state_d = (op == OP_HLT) ? S_HALT : S_FETCH0;
        end
      end
      S_EXEC: begin
        if ((op == OP_STA) || done) begin
          retire  = 1'b1;
          state_d = S_FETCH0;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH0;
    endcase
    if (rst) begin
      state_d = S_FETCH0;
      retire  = 1'b0;
    end
  end

  // Saturate instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (rst)
      cnt_d = '0;
    else if (retire && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_comb begin
    pc_set  = 1'b0;
    pc_inc  = 1'b0;
    mar_set = 1'b0;
    mar_src = 1'b0;
    ir_set  = 1'b0;
    acc_set = 1'b0;
    alu_op  = ALU_PASS;
    mem_we  = 1'b0;
    halted  = 1'b0;
    if (!rst) begin
      unique case (state_q)
        S_FETCH0: mar_set = run;
        S_FETCH1: begin
          ir_set = done;
          pc_inc = done;
        end
        S_DECODE: begin
          mar_set = is_mem(op);
          mar_src = is_mem(op);
          pc_set  = (op == OP_JMP) ||
                    ((op == OP_JZ) && acc_zero);
        end
        S_EXEC: begin
          if (op == OP_STA) begin
            mem_we = 1'b1;
          end else if (done) begin
            acc_set = 1'b1;
            alu_op  = alu_sel(op);
          end
        end
        S_HALT:  halted = 1'b1;
        default: halted = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
  end

endmodule

// File: tb/tb_acc_ctrl_seq.sv
// Bench for acc_ctrl_seq: three configurations checked against
// an instruction-level schedule model, plus literal pins.
module tb_acc_ctrl_seq;

  typedef struct packed {
    logic [10:0] v;
    logic        ret;
    logic        hlt;
  } ent_t;

  // vector: pc_set pc_inc mar_set mar_src ir_set acc_set alu[2] mem_we halted clr_n
  localparam logic [10:0] V_IDLE = 11'h001;
  localparam logic [10:0] V_MAR0 = 11'h101;
  localparam logic [10:0] V_IRPC = 11'h241;
  localparam logic [10:0] V_MAR1 = 11'h181;
  localparam logic [10:0] V_ACC  = 11'h021;
  localparam logic [10:0] V_PC   = 11'h401;
  localparam logic [10:0] V_MEMW = 11'h005;
  localparam logic [10:0] V_HALT = 11'h003;

  int LAT[3]  = '{1, 3, 1};
  int CMAX[3] = '{65535, 65535, 3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] run;
  logic [2:0] az;
  logic [2:0] op [3];

  logic       clr_n [3];
  logic       pc_set [3];
  logic       pc_inc [3];
  logic       mar_set [3];
  logic       mar_src [3];
  logic       ir_set [3];
  logic       acc_set [3];
  logic [1:0] alu [3];
  logic       mem_we [3];
  logic       halted [3];
  logic [15:0] cnt0;
  logic [15:0] cnt1;
  logic [1:0]  cnt2;

  logic [10:0] act [3];
  logic [15:0] cact [3];

  int tests = 0;
  int fails = 0;

  ent_t sch [3][8];
  int   slen [3];
  int   spos [3];
  bit   mh [3];
  int   mc [3];

  acc_ctrl_seq #(.OP_W(3), .CNT_W(16), .MEM_LAT(1)) u_dut0 (
    .clk(clk), .rst(rst), .run(run[0]), .ir_op(op[0]),
    .acc_zero(az[0]), .reg_clr_n(clr_n[0]), .pc_set(pc_set[0]),
    .pc_inc(pc_inc[0]), .mar_set(mar_set[0]), .mar_src(mar_src[0]),
    .ir_set(ir_set[0]), .acc_set(acc_set[0]), .alu_op(alu[0]),
    .mem_we(mem_we[0]), .halted(halted[0]), .instr_cnt(cnt0)
  );

  acc_ctrl_seq #(.OP_W(3), .CNT_W(16), .MEM_LAT(3)) u_dut1 (
    .clk(clk), .rst(rst), .run(run[1]), .ir_op(op[1]),
    .acc_zero(az[1]), .reg_clr_n(clr_n[1]), .pc_set(pc_set[1]),
    .pc_inc(pc_inc[1]), .mar_set(mar_set[1]), .mar_src(mar_src[1]),
    .ir_set(ir_set[1]), .acc_set(acc_set[1]), .alu_op(alu[1]),
    .mem_we(mem_we[1]), .halted(halted[1]), .instr_cnt(cnt1)
  );

  acc_ctrl_seq #(.OP_W(3), .CNT_W(2), .MEM_LAT(1)) u_dut2 (
    .clk(clk), .rst(rst), .run(run[2]), .ir_op(op[2]),
    .acc_zero(az[2]), .reg_clr_n(clr_n[2]), .pc_set(pc_set[2]),
    .pc_inc(pc_inc[2]), .mar_set(mar_set[2]), .mar_src(mar_src[2]),
    .ir_set(ir_set[2]), .acc_set(acc_set[2]), .alu_op(alu[2]),
    .mem_we(mem_we[2]), .halted(halted[2]), .instr_cnt(cnt2)
  );

  always_comb begin
    for (int k = 0; k < 3; k++)
      act[k] = {pc_set[k], pc_inc[k], mar_set[k], mar_src[k],
                ir_set[k], acc_set[k], alu[k], mem_we[k],
                halted[k], clr_n[k]};
  end

  assign cact[0] = cnt0;
  assign cact[1] = cnt1;
  assign cact[2] = {14'd0, cnt2};

  task automatic chk(string nm, int k, int a, int e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s[%0d] got %0h expected %0h at %0t",
               nm, k, a, e, $time);
    end
  endtask

  function automatic bit idle(int k);
    return (spos[k] >= slen[k]) && !mh[k];
  endfunction

  function automatic void push(int k, logic [10:0] v,
                               logic r, logic h);
    sch[k][slen[k]] = '{v: v, ret: r, hlt: h};
    slen[k]++;
  endfunction

  function automatic logic [1:0] alu_of(logic [2:0] o);
    case (o)
      3'b010:  return 2'b01;
      3'b011:  return 2'b10;
      3'b100:  return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // Whole-instruction cycle schedule, from the cycle after FETCH0.
  function automatic void build(int k);
    logic [2:0] o;
    o = op[k];
    slen[k] = 0;
    spos[k] = 0;
    for (int i = 0; i < LAT[k] - 1; i++) push(k, V_IDLE, 0, 0);
    push(k, V_IRPC, 0, 0);
    case (o)
      3'b000, 3'b010, 3'b011, 3'b100: begin
        push(k, V_MAR1, 0, 0);
        for (int i = 0; i < LAT[k] - 1; i++) push(k, V_IDLE, 0, 0);
        push(k, V_ACC | {6'd0, alu_of(o), 3'd0}, 1, 0);
      end
      3'b001: begin
        push(k, V_MAR1, 0, 0);
        push(k, V_MEMW, 1, 0);
      end
      3'b101: push(k, V_PC, 1, 0);
      3'b110: push(k, az[k] ? V_PC : V_IDLE, 1, 0);
      default: push(k, V_IDLE, 1, 1);
    endcase
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      ent_t e;
      e = '{v: V_IDLE, ret: 1'b0, hlt: 1'b0};
      chk("instr_cnt", k, cact[k], mc[k]);
      if (rst) begin
        e.v = '0;
        slen[k] = 0;
        spos[k] = 0;
        mh[k] = 0;
      end else if (mh[k]) begin
        e.v = V_HALT;
      end else if (spos[k] >= slen[k]) begin
        if (run[k]) begin
          e.v = V_MAR0;
          build(k);
        end
      end else begin
        e = sch[k][spos[k]];
        spos[k]++;
      end
      chk("outputs", k, act[k], e.v);
      if (rst) mc[k] = 0;
      else if (e.ret && mc[k] < CMAX[k]) mc[k]++;
      if (e.hlt) mh[k] = 1;
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(int k, string nm, logic [10:0] v);
    @(negedge clk);
    chk(nm, k, act[k], v);
    nxt();
  endtask

  task automatic lit_cnt(int k, string nm, int v);
    @(negedge clk);
    chk(nm, k, cact[k], v);
    nxt();
  endtask

  task automatic issue(int k, logic [2:0] o);
    op[k] = o;
    run[k] = 1'b1;
    nxt();
    run[k] = 1'b0;
    for (int i = 0; i < 20 && !idle(k); i++) nxt();
    if (!idle(k)) chk("issue_timeout", k, 0, 1);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      slen[k] = 0; spos[k] = 0; mh[k] = 0; mc[k] = 0;
      op[k] = 3'b000;
    end
    rst = 1'b1;
    run = '0;
    az  = '0;
    nxt();
    nxt();
    rst = 1'b0;

    for (int i = 0; i < 5; i++) lit(0, "run0_idle", V_IDLE);
    op[0] = 3'b000;
    run[0] = 1'b1;
    lit(0, "lda_fetch0", V_MAR0);
    run[0] = 1'b0;
    lit(0, "lda_fetch1", V_IRPC);
    lit(0, "lda_decode", V_MAR1);
    lit(0, "lda_exec", 11'h021);
    lit_cnt(0, "lda_cnt", 1);

    op[0] = 3'b110;
    az[0] = 1'b1;
    run[0] = 1'b1;
    lit(0, "jz1_fetch0", V_MAR0);
    run[0] = 1'b0;
    lit(0, "jz1_fetch1", V_IRPC);
    lit(0, "jz1_decode", 11'h401);
    az[0] = 1'b0;
    run[0] = 1'b1;
    lit(0, "jz0_fetch0", V_MAR0);
    run[0] = 1'b0;
    lit(0, "jz0_fetch1", V_IRPC);
    lit(0, "jz0_decode", 11'h001);
    lit_cnt(0, "jz_cnt", 3);

    op[1] = 3'b011;
    run[1] = 1'b1;
    lit(1, "sub_fetch0", V_MAR0);
    run[1] = 1'b0;
    lit(1, "sub_f1_w0", V_IDLE);
    lit(1, "sub_f1_w1", V_IDLE);
    lit(1, "sub_f1_last", V_IRPC);
    lit(1, "sub_decode", V_MAR1);
    lit(1, "sub_ex_w0", V_IDLE);
    lit(1, "sub_ex_w1", V_IDLE);
    lit(1, "sub_ex_last", 11'h031);
    lit_cnt(1, "sub_cnt", 1);

    for (int i = 0; i < 3; i++) issue(2, 3'b101);
    lit_cnt(2, "sat_pre", 3);
    op[2] = 3'b001;
    run[2] = 1'b1;
    lit(2, "sta_fetch0", V_MAR0);
    run[2] = 1'b0;
    lit(2, "sta_fetch1", V_IRPC);
    lit(2, "sta_decode", V_MAR1);
    lit(2, "sta_exec", 11'h005);
    lit(2, "sta_after", V_IDLE);
    op[2] = 3'b111;
    run[2] = 1'b1;
    lit(2, "hlt_fetch0", V_MAR0);
    run[2] = 1'b0;
    lit(2, "hlt_fetch1", V_IRPC);
    lit(2, "hlt_decode", V_IDLE);
    run[2] = 1'b1;
    for (int i = 0; i < 3; i++) lit(2, "halt_hold", 11'h003);
    run[2] = 1'b0;
    lit_cnt(2, "sat_cnt", 3);

    op[0] = 3'b010;
    run[0] = 1'b1;
    lit(0, "add_fetch0", V_MAR0);
    run[0] = 1'b0;
    lit(0, "add_fetch1", V_IRPC);
    lit(0, "add_decode", V_MAR1);
    rst = 1'b1;
    lit(0, "rst_cyc1", 11'h000);
    lit(0, "rst_cyc2", 11'h000);
    rst = 1'b0;
    lit_cnt(0, "rst_cnt", 0);
    lit(0, "rst_idle", V_IDLE);

    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int k = 0; k < 3; k++) begin
        if (idle(k)) begin
          int r;
          r = $urandom_range(0, 15);
          op[k] = (r == 15) ? 3'b111 : 3'(r % 7);
          az[k] = 1'($urandom_range(0, 1));
          run[k] = ($urandom_range(0, 2) != 0);
        end else begin
          run[k] = 1'($urandom_range(0, 1));
        end
      end
      nxt();
    end
    rst = 1'b0;
    run = '0;
    nxt();
    nxt();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
